// File: rtl/rv_plic_gateway.sv
// rtl/rv_plic_gateway.sv - per-source PLIC interrupt gateway; optional input synchronizer via RV_PLIC_GATEWAY_SYNC_EN
module rv_plic_gateway #(
    parameter int N_SOURCE = 32,
    parameter int CNTW     = 4,
    localparam int SRCW    = $clog2(N_SOURCE + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_SOURCE-1:0] src_i,
    input  logic [N_SOURCE-1:0] le_i,
    input  logic                claim_i,
    input  logic [SRCW-1:0]     claim_id_i,
    input  logic                complete_i,
    input  logic [SRCW-1:0]     complete_id_i,
    output logic [N_SOURCE-1:0] ip_o,
    output logic [N_SOURCE-1:0] active_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_e;

    state_e              state_q [N_SOURCE];
    state_e              state_d [N_SOURCE];
    logic [CNTW-1:0]     cnt_q   [N_SOURCE];
    logic [CNTW-1:0]     cnt_d   [N_SOURCE];
    logic [N_SOURCE-1:0] src_s;
    logic [N_SOURCE-1:0] src_q;
    logic [N_SOURCE-1:0] edge_v;
    logic [N_SOURCE-1:0] take;

`ifdef RV_PLIC_GATEWAY_SYNC_EN
    logic [N_SOURCE-1:0] sync_q1;
    logic [N_SOURCE-1:0] sync_q2;

    // Two-flop synchronizer so device lines may be asynchronous to clk_i
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= src_i;
            sync_q2 <= sync_q1;
        end
    end

    assign src_s = sync_q2;
`else
    assign src_s = src_i;
`endif

    // src_q resets to 0 so a line already high after reset is seen as an edge
    assign edge_v = src_s & ~src_q;

    // Per-source next state and edge counter; claim is only honoured in
    // PENDING and complete only in ACTIVE, so same-ID collisions resolve to the claim
    always_comb begin
        for (int i = 0; i < N_SOURCE; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            take[i]    = 1'b0;
            case (state_q[i])
                ST_IDLE: begin
                    if (le_i[i]) begin
                        if (edge_v[i] || (cnt_q[i] != '0)) begin
                            state_d[i] = ST_PENDING;
                            take[i]    = 1'b1;
                        end
                    end else if (src_s[i]) begin
                        state_d[i] = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (claim_i && (claim_id_i == SRCW'(i + 1))) begin
                        state_d[i] = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (complete_i && (complete_id_i == SRCW'(i + 1))) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
            // An edge consumed by a same-cycle take leaves the count unchanged
            if (!le_i[i]) begin
                cnt_d[i] = '0;
            end else if (take[i] && !edge_v[i]) begin
                cnt_d[i] = cnt_q[i] - CNTW'(1);
            end else if (!take[i] && edge_v[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNTW'(1);
            end
        end
    end

    // State, counter, edge history and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q    <= '0;
            ip_o     <= '0;
            active_o <= '0;
            for (int i = 0; i < N_SOURCE; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            src_q <= src_s;
            for (int i = 0; i < N_SOURCE; i++) begin
                state_q[i]  <= state_d[i];
                cnt_q[i]    <= cnt_d[i];
                ip_o[i]     <= (state_d[i] == ST_PENDING);
                active_o[i] <= (state_d[i] == ST_ACTIVE);
            end
        end
    end

endmodule

// File: tb/tb_rv_plic_gateway.sv
// tb/tb_rv_plic_gateway.sv - self-checking bench for rv_plic_gateway with a behavioural model
module tb_rv_plic_gateway;

    localparam int N    = 32;
    localparam int CNTW = 2;
    localparam int SRCW = 6;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    src = '0;
    logic [N-1:0]    le = '0;
    logic            claim = 1'b0;
    logic [SRCW-1:0] claim_id = '0;
    logic            complete = 1'b0;
    logic [SRCW-1:0] complete_id = '0;
    logic [N-1:0]    ip;
    logic [N-1:0]    active;

    int n_cmp = 0;
    int n_err = 0;

    rv_plic_gateway #(.N_SOURCE(N), .CNTW(CNTW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .src_i        (src),
        .le_i         (le),
        .claim_i      (claim),
        .claim_id_i   (claim_id),
        .complete_i   (complete),
        .complete_id_i(complete_id),
        .ip_o         (ip),
        .active_o     (active)
    );

    always #5 clk = ~clk;

    // Behavioural model: each source holds at most one request (0 idle,
    // 1 waiting for claim, 2 in service) plus a count of queued edges
    int m_mode [N];
    int m_cnt  [N];
    bit m_prev [N];
    bit m_s1   [N];
    bit m_s2   [N];
    bit started = 0;

    initial begin
        for (int i = 0; i < N; i++) begin
            m_mode[i] = 0; m_cnt[i] = 0; m_prev[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
        end
    end

    always @(posedge clk) begin : model
        bit line;
        bit rise;
        bit took;
        if (rst) begin
            started = 1;
            for (int i = 0; i < N; i++) begin
                m_mode[i] = 0; m_cnt[i] = 0; m_prev[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
`ifdef RV_PLIC_GATEWAY_SYNC_EN
                line = m_s2[i];
`else
                line = src[i];
`endif
                rise = line && !m_prev[i];
                took = 0;
                if (m_mode[i] == 0) begin
                    if (le[i] ? (rise || m_cnt[i] > 0) : line) begin
                        m_mode[i] = 1;
                        took = le[i];
                    end
                end else if (m_mode[i] == 1) begin
                    if (claim && int'(claim_id) == i + 1) m_mode[i] = 2;
                end else begin
                    if (complete && int'(complete_id) == i + 1) m_mode[i] = 0;
                end
                if (!le[i]) m_cnt[i] = 0;
                else begin
                    m_cnt[i] = m_cnt[i] + int'(rise) - int'(took);
                    if (m_cnt[i] > CMAX) m_cnt[i] = CMAX;
                end
                m_prev[i] = line;
                m_s2[i] = m_s1[i];
                m_s1[i] = src[i];
            end
        end
    end

    function automatic logic [N-1:0] exp_vec(int mode);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = (m_mode[i] == mode);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            chk("model_ip", ip, exp_vec(1));
            chk("model_active", active, exp_vec(2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int i);
        src[i] = 1'b1; tick();
        src[i] = 1'b0; tick();
    endtask

    task automatic do_claim(input int id);
        claim = 1'b1; claim_id = SRCW'(id); tick();
        claim = 1'b0; claim_id = '0;
    endtask

    task automatic do_complete(input int id);
        complete = 1'b1; complete_id = SRCW'(id); tick();
        complete = 1'b0; complete_id = '0;
    endtask

    initial begin
        int episodes;
        tick(); tick();
        rst = 1'b0;
        chk("reset_ip", ip, 32'h0);
        chk("reset_active", active, 32'h0);

        // Level source 3
        src[2] = 1'b1; tick();
        chk("lvl_pend", ip, 32'h4);
        tick();
        do_claim(3);
        chk("lvl_claim_ip", ip, 32'h0);
        chk("lvl_claim_act", active, 32'h4);
        tick(); tick();
        do_complete(3);
        chk("lvl_cmpl_act", active, 32'h0);
        chk("lvl_cmpl_ip", ip, 32'h0);
        tick();
        chk("lvl_repend", ip, 32'h4);
        src[2] = 1'b0;
        do_claim(3);
        do_complete(3);
        tick();
        chk("lvl_done", ip | active, 32'h0);

        // Edge counting, source 1
        le[0] = 1'b1;
        src[0] = 1'b1; tick();
        chk("edge_first", ip, 32'h1);
        src[0] = 1'b0; tick();
        pulse(0); pulse(0);
        for (int k = 0; k < 3; k++) begin
            do_claim(1);
            chk("edge_claim", active, 32'h1);
            do_complete(1);
            tick();
            chk("edge_repend", ip, (k < 2) ? 32'h1 : 32'h0);
        end

        // Saturation: five edges while in service leave three queued
        pulse(0);
        do_claim(1);
        for (int k = 0; k < 5; k++) pulse(0);
        chk("sat_model_cnt", m_cnt[0], 32'd3);
        episodes = 0;
        for (int k = 0; k < 5; k++) begin
            do_complete(1);
            tick();
            if (ip[0]) begin
                episodes++;
                do_claim(1);
            end
        end
        chk("sat_episodes", episodes, 32'd3);
        chk("sat_idle", ip | active, 32'h0);

        // Illegal strobes with source 2 pending and source 7 in service
        src[1] = 1'b1; tick();
        src[6] = 1'b1; tick();
        src[6] = 1'b0;
        do_claim(7);
        chk("ill_setup_ip", ip, 32'h2);
        chk("ill_setup_act", active, 32'h40);
        do_claim(0);
        chk("ill_claim0", {ip[15:0], active[15:0]}, 32'h0002_0040);
        do_claim(33);
        chk("ill_claim33", {ip[15:0], active[15:0]}, 32'h0002_0040);
        do_complete(5);
        chk("ill_cmpl_idle", {ip[15:0], active[15:0]}, 32'h0002_0040);
        do_claim(5);
        chk("ill_claim_idle", {ip[15:0], active[15:0]}, 32'h0002_0040);

        // Simultaneous claim 2 and complete 7
        claim = 1'b1; claim_id = 6'd2; complete = 1'b1; complete_id = 6'd7;
        tick();
        claim = 1'b0; complete = 1'b0;
        chk("sim_ip", ip, 32'h0);
        chk("sim_act", active, 32'h2);
        src[1] = 1'b0;
        do_complete(2);
        src[1] = 1'b1; tick();
        src[1] = 1'b0;
        chk("same_pend", ip, 32'h2);
        claim = 1'b1; claim_id = 6'd2; complete = 1'b1; complete_id = 6'd2;
        tick();
        claim = 1'b0; complete = 1'b0;
        chk("same_claim_wins", active, 32'h2);
        do_complete(2);

        // Reset mid-operation
        src[3] = 1'b1; tick();
        src[3] = 1'b0;
        do_claim(4);
        src[2] = 1'b1; tick();
        src[2] = 1'b0;
        pulse(0); pulse(0); pulse(0);
        chk("rst_pre_ip", ip, 32'h5);
        chk("rst_pre_act", active, 32'h8);
        chk("rst_pre_cnt", m_cnt[0], 32'd2);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("rst_ip", ip, 32'h0);
        chk("rst_act", active, 32'h0);
        tick(); tick(); tick();
        chk("rst_stay_idle", ip | active, 32'h0);

        // Randomised traffic; the per-cycle compare checks against the model
        for (int c = 0; c < 3000; c++) begin
            src = $urandom() & $urandom();
            if ((c % 64) == 0) le = $urandom();
            claim = ($urandom_range(0, 1) == 1);
            claim_id = ($urandom_range(0, 9) == 0) ? SRCW'($urandom_range(33, 63))
                                                   : SRCW'($urandom_range(0, 9));
            complete = ($urandom_range(0, 2) != 0);
            complete_id = SRCW'($urandom_range(0, 9));
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0; claim = 1'b0; complete = 1'b0; src = '0;
        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
